fc_layer_engine: RTL and testbench

//  Parametrised fully-connected layer: IN_FEATURES fixed-point inputs x OUT_NEURONS neurons, per-neuron weight RAM + bias, written by RISC-V.
//  One MAC lane per neuron, one input feature per cycle; bias add, saturate, optional ReLU.

---
 rtl/fc_engine_pkg.sv | 32 +++
 rtl/fc_mac_lane.sv | 72 +++++++
 rtl/fc_layer_engine.sv | 139 +++++++++++++
 tb/tb_fc_layer_engine.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_engine_pkg.sv
// Shared types and helpers for the fully-connected layer engine:
// FSM state encoding, accumulator sizing and signed saturation.
package fc_engine_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_MAC  = 2'd1;
   localparam state_t ST_BIAS = 2'd2;
   localparam state_t ST_DONE = 2'd3;

   localparam int SAT_W = 128;

   function automatic int acc_width(input int dw, input int n);
      return 2 * dw + $clog2(n);
   endfunction

   // Clamp a wide signed value into the signed range of a dw-bit word.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] v,
      input int dw
   );
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      hi = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
      lo = ~hi;
      if (v > hi) return hi;
      else if (v < lo) return lo;
      else return v;
   endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One neuron: weight RAM, accumulator, bias add, saturation and
// optional ReLU (enabled by defining FC_RELU_EN).
module fc_mac_lane
   import fc_engine_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int FRAC_BITS   = 16,
   parameter int IN_FEATURES = 100,
   parameter int ACC_WIDTH   = 71,
   parameter int AW          = 7
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  rd_en,
   input  logic [AW-1:0]         raddr,
   input  logic                  acc_clr,
   input  logic                  acc_en,
   input  logic [DATA_WIDTH-1:0] x,
   input  logic [DATA_WIDTH-1:0] bias,
   input  logic                  bias_en,
   output logic [DATA_WIDTH-1:0] y
);

   localparam int PW = 2 * DATA_WIDTH;

   logic [DATA_WIDTH-1:0]        mem [IN_FEATURES];
   logic [DATA_WIDTH-1:0]        rdata_q;
   logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
   logic [DATA_WIDTH-1:0]        y_q, y_d;
   logic signed [PW-1:0]         prod;
   logic signed [SAT_W-1:0]      sum, sat;
   logic [DATA_WIDTH-1:0]        y_sat, y_act;

   // Weight storage survives reset; reads are one-cycle synchronous.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rd_en) rdata_q <= mem[raddr];
   end

   always_comb begin
      acc_d = acc_q;
      y_d   = y_q;
      prod  = PW'($signed(rdata_q)) * PW'($signed(x));
      sum   = (SAT_W'(acc_q) >>> FRAC_BITS) + SAT_W'($signed(bias));
      sat   = saturate(sum, DATA_WIDTH);
      y_sat = sat[DATA_WIDTH-1:0];
`ifdef FC_RELU_EN
      y_act = y_sat[DATA_WIDTH-1] ? '0 : y_sat;
`else
      y_act = y_sat;
`endif
      if (acc_clr) acc_d = '0;
      else if (acc_en) acc_d = acc_q + ACC_WIDTH'(prod);
      if (bias_en) y_d = y_act;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q <= '0;
         y_q   <= '0;
      end else begin
         acc_q <= acc_d;
         y_q   <= y_d;
      end
   end

   assign y = y_q;

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: FSM, feature counter, input latch, bias RAM and
// OUT_NEURONS MAC lanes. Define FC_RELU_EN to clamp negative outputs to 0.
module fc_layer_engine
   import fc_engine_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int FRAC_BITS    = 16,
   parameter int IN_FEATURES  = 100,
   parameter int OUT_NEURONS  = 10,
   parameter int ADDRESS_BITS = 17
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DATA_WIDTH-1:0]             riscv_data,
   input  logic [ADDRESS_BITS-1:0]           riscv_address,
   input  logic [OUT_NEURONS-1:0]            wm_enable_write,
   input  logic                              bm_enable_write,
   input  logic                              start_from_previous,
   input  logic [IN_FEATURES*DATA_WIDTH-1:0] ifm_data,
   output logic                              end_to_previous,
   output logic [OUT_NEURONS*DATA_WIDTH-1:0] fc_out,
   output logic                              enable_write_next,
   output logic                              output_ready,
   output logic                              busy
);

   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, IN_FEATURES);
   localparam int AW = (IN_FEATURES > 1) ? $clog2(IN_FEATURES) : 1;
   localparam int BW = (OUT_NEURONS > 1) ? $clog2(OUT_NEURONS) : 1;
   localparam int KW = $clog2(IN_FEATURES + 1);

   state_t                            state_q, state_d;
   logic [KW-1:0]                     k_q, k_d;
   logic                              etp_q, etp_d;
   logic                              acc_en_q, acc_en_d;
   logic [DATA_WIDTH-1:0]             x_q, x_d;
   logic [IN_FEATURES*DATA_WIDTH-1:0] ifm_q, ifm_d;
   logic                              acc_clr, rd_en, bias_en;
   logic [DATA_WIDTH-1:0]             bias_mem [OUT_NEURONS];
   logic [AW-1:0]                     waddr;
   logic [BW-1:0]                     baddr;
   logic                              idle, waddr_ok, baddr_ok;
   logic                              unused_addr_hi;

   assign idle     = (state_q == ST_IDLE);
   assign waddr    = riscv_address[AW-1:0];
   assign baddr    = riscv_address[BW-1:0];
   assign waddr_ok = int'(waddr) < IN_FEATURES;
   assign baddr_ok = int'(baddr) < OUT_NEURONS;
   assign unused_addr_hi = ^riscv_address[ADDRESS_BITS-1:AW];

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      ifm_d    = ifm_q;
      x_d      = x_q;
      etp_d    = 1'b0;
      acc_en_d = 1'b0;
      acc_clr  = 1'b0;
      rd_en    = 1'b0;
      bias_en  = 1'b0;
      unique case (state_q)
         ST_IDLE: if (start_from_previous) begin
            ifm_d   = ifm_data;
            k_d     = '0;
            acc_clr = 1'b1;
            etp_d   = 1'b1;
            state_d = ST_MAC;
         end
         // k == IN_FEATURES is the drain cycle for the last product.
         ST_MAC: if (k_q == KW'(IN_FEATURES)) begin
            state_d = ST_BIAS;
         end else begin
            rd_en    = 1'b1;
            acc_en_d = 1'b1;
            x_d      = ifm_q[int'(k_q)*DATA_WIDTH +: DATA_WIDTH];
            k_d      = k_q + KW'(1);
         end
         ST_BIAS: begin
            bias_en = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         k_q      <= '0;
         etp_q    <= 1'b0;
         acc_en_q <= 1'b0;
         x_q      <= '0;
      end else begin
         state_q  <= state_d;
         k_q      <= k_d;
         etp_q    <= etp_d;
         acc_en_q <= acc_en_d;
         x_q      <= x_d;
      end
   end

   always_ff @(posedge clk) begin
      ifm_q <= ifm_d;
      if (bm_enable_write && idle && baddr_ok)
         bias_mem[baddr] <= riscv_data;
   end

   for (genvar g = 0; g < OUT_NEURONS; g++) begin : g_lane
      fc_mac_lane #(
         .DATA_WIDTH  (DATA_WIDTH),
         .FRAC_BITS   (FRAC_BITS),
         .IN_FEATURES (IN_FEATURES),
         .ACC_WIDTH   (ACC_WIDTH),
         .AW          (AW)
      ) u_lane (
         .clk     (clk),
         .reset   (reset),
         .we      (wm_enable_write[g] && idle && waddr_ok),
         .waddr   (waddr),
         .wdata   (riscv_data),
         .rd_en   (rd_en),
         .raddr   (k_q[AW-1:0]),
         .acc_clr (acc_clr),
         .acc_en  (acc_en_q),
         .x       (x_q),
         .bias    (bias_mem[g]),
         .bias_en (bias_en),
         .y       (fc_out[g*DATA_WIDTH +: DATA_WIDTH])
      );
   end

   assign end_to_previous   = etp_q;
   assign output_ready      = (state_q == ST_DONE);
   assign enable_write_next = (state_q == ST_DONE);
   assign busy              = !idle;

endmodule

// File: tb/tb_fc_layer_engine.sv
// Scoreboard bench for fc_layer_engine: driver pushes expected results,
// a negedge monitor pops and compares on every output pulse.
module tb_fc_layer_engine;

   localparam int DW  = 32;
   localparam int IN  = 100;
   localparam int OUT = 10;
   localparam int AB  = 17;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [DW-1:0]     riscv_data = '0;
   logic [AB-1:0]     riscv_address = '0;
   logic [OUT-1:0]    wm_enable_write = '0;
   logic              bm_enable_write = 1'b0;
   logic              start_from_previous = 1'b0;
   logic [IN*DW-1:0]  ifm_data = '0;
   logic              end_to_previous;
   logic [OUT*DW-1:0] fc_out;
   logic              enable_write_next;
   logic              output_ready;
   logic              busy;

   typedef struct {
      logic [OUT*DW-1:0] v;
      int                cyc;
   } exp_t;

   exp_t exp_q[$];
   int   etp_q[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   fc_layer_engine #(
      .DATA_WIDTH(DW), .FRAC_BITS(16), .IN_FEATURES(IN),
      .OUT_NEURONS(OUT), .ADDRESS_BITS(AB)
   ) dut (
      .clk(clk), .reset(reset), .riscv_data(riscv_data),
      .riscv_address(riscv_address), .wm_enable_write(wm_enable_write),
      .bm_enable_write(bm_enable_write),
      .start_from_previous(start_from_previous), .ifm_data(ifm_data),
      .end_to_previous(end_to_previous), .fc_out(fc_out),
      .enable_write_next(enable_write_next), .output_ready(output_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (output_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ready cyc=%0d", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (cyc != e.cyc) begin
               bad++;
               $display("FAIL ready_cycle got=%0d want=%0d", cyc, e.cyc);
            end
            total++;
            if (fc_out !== e.v) begin
               bad++;
               $display("FAIL fc_out got=%h want=%h", fc_out, e.v);
            end
            total++;
            if (enable_write_next !== 1'b1) begin
               bad++;
               $display("FAIL ewn_with_ready got=%b want=1", enable_write_next);
            end
         end
      end else if (enable_write_next) begin
         total++;
         bad++;
         $display("FAIL ewn_without_ready cyc=%0d", cyc);
      end
      if (end_to_previous) begin
         total++;
         if (etp_q.size() == 0 || etp_q[0] != cyc) begin
            bad++;
            $display("FAIL etp_cycle got=%0d want=%0d", cyc,
                     (etp_q.size() == 0) ? -1 : etp_q[0]);
         end
         if (etp_q.size() != 0) void'(etp_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [OUT*DW-1:0] act,
                      input logic [OUT*DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [OUT*DW-1:0] lanes(input logic [DW-1:0] v);
      logic [OUT*DW-1:0] r;
      for (int n = 0; n < OUT; n++) r[n*DW +: DW] = v;
      return r;
   endfunction

   task automatic load_w(input logic [DW-1:0] d);
      wm_enable_write = '1;
      riscv_data = d;
      for (int k = 0; k < IN; k++) begin
         riscv_address = AB'(k);
         tick();
      end
      wm_enable_write = '0;
   endtask

   task automatic load_b(input int n, input logic [DW-1:0] d);
      bm_enable_write = 1'b1;
      riscv_address = AB'(n);
      riscv_data = d;
      tick();
      bm_enable_write = 1'b0;
   endtask

   task automatic set_x(input logic [DW-1:0] d);
      for (int k = 0; k < IN; k++) ifm_data[k*DW +: DW] = d;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
      total++;
      if (busy) begin
         bad++;
         $display("FAIL idle_timeout cyc=%0d", cyc);
      end
   endtask

   task automatic run(input logic [OUT*DW-1:0] v);
      exp_q.push_back('{v: v, cyc: cyc + 103});
      etp_q.push_back(cyc + 1);
      start_from_previous = 1'b1;
      tick();
      start_from_previous = 1'b0;
      wait_idle();
   endtask

   initial begin
      logic [OUT*DW-1:0] v;
      int c0;
      repeat (3) tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_busy", OUT*DW'(busy), '0);
      chk("rst_fc_out", fc_out, '0);
      chk("rst_etp", OUT*DW'(end_to_previous), '0);
      chk("rst_ready", OUT*DW'(output_ready), '0);
      tick();

      load_w(32'h0001_0000);
      for (int n = 0; n < OUT; n++) load_b(n, 32'h0);
      set_x(32'h0001_0000);
      run(lanes(32'h0064_0000));

      // abort mid-inference
      c0 = cyc;
      etp_q.push_back(c0 + 1);
      start_from_previous = 1'b1;
      tick();
      start_from_previous = 1'b0;
      while (cyc < c0 + 50) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", OUT*DW'(busy), '0);
      chk("abort_fc_out", fc_out, '0);
      repeat (110) tick();
      run(lanes(32'h0064_0000));

      // three back-to-back inferences, W write attempted during MAC
      c0 = cyc;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back('{v: lanes(32'h0064_0000), cyc: c0 + 103 + 104*i});
         etp_q.push_back(c0 + 1 + 104*i);
      end
      start_from_previous = 1'b1;
      while (cyc < c0 + 20) tick();
      chk("busy_in_mac", OUT*DW'(busy), OUT*DW'(1));
      wm_enable_write = '1;
      riscv_address = '0;
      riscv_data = 32'h7FFF_0000;
      tick();
      wm_enable_write = '0;
      while (cyc < c0 + 250) tick();
      start_from_previous = 1'b0;
      wait_idle();
      repeat (3) tick();

      set_x(32'h0);
      load_b(3, 32'hFFFD_8000);
      v = '0;
`ifdef FC_RELU_EN
      v[3*DW +: DW] = 32'h0;
`else
      v[3*DW +: DW] = 32'hFFFD_8000;
`endif
      run(v);

      load_b(3, 32'h0);
      load_w(32'h7FFF_0000);
      set_x(32'h7FFF_0000);
      run(lanes(32'h7FFF_FFFF));

      load_w(32'h8000_0000);
`ifdef FC_RELU_EN
      run(lanes(32'h0));
`else
      run(lanes(32'h8000_0000));
`endif

      // -1 ulp * 1 ulp summed 100 times floors to -1
      load_w(32'hFFFF_FFFF);
      set_x(32'h0000_0001);
`ifdef FC_RELU_EN
      run(lanes(32'h0));
`else
      run(lanes(32'hFFFF_FFFF));
`endif

      load_w(32'h0000_8000);
      set_x(32'h0002_0000);
      v = '0;
      for (int n = 0; n < OUT; n++) begin
         load_b(n, 32'(n) << 16);
         v[n*DW +: DW] = 32'h0064_0000 + (32'(n) << 16);
      end
      run(v);

      repeat (5) tick();
      chk("fc_out_hold", fc_out, v);
      chk("exp_q_empty", OUT*DW'(exp_q.size()), '0);
      chk("etp_q_empty", OUT*DW'(etp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
